// File: rtl/online_div_ctrl_v3_if.sv
`default_nettype none
// ============================================================================
// Module      : online_div_ctrl_v3_if
// Description : Control/stream bundle of the online divider sequencer.
//               Macro OLDIV_CTRL_ABORT_EN adds the abort/aborted pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface online_div_ctrl_v3_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = 11,
    parameter int DIGIT_W    = 2
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] num_iter;
    logic                  in_valid;
    logic [DIGIT_W-1:0]    x_in;
    logic [DIGIT_W-1:0]    y_in;
    logic                  in_ready;
    logic [DIGIT_W-1:0]    x_value;
    logic [DIGIT_W-1:0]    y_value;
    logic                  enable;
    logic                  add_enable;
    logic                  res_enable;
    logic [CNT_WIDTH-1:0]  counter;
    logic [CNT_WIDTH-1:0]  shift_cnt;
    logic [ADDR_WIDTH-1:0] rest_cycle;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  finish_vec;
    logic                  busy;
    logic                  done;
`ifdef OLDIV_CTRL_ABORT_EN
    logic                  abort;
    logic                  aborted;

    modport master (
        output start, num_iter, in_valid, x_in, y_in, abort,
        input  in_ready, x_value, y_value, enable, add_enable, res_enable,
               counter, shift_cnt, rest_cycle, rd_addr, finish_vec, busy, done,
               aborted
    );

    modport slave (
        input  start, num_iter, in_valid, x_in, y_in, abort,
        output in_ready, x_value, y_value, enable, add_enable, res_enable,
               counter, shift_cnt, rest_cycle, rd_addr, finish_vec, busy, done,
               aborted
    );
`else
    modport master (
        output start, num_iter, in_valid, x_in, y_in,
        input  in_ready, x_value, y_value, enable, add_enable, res_enable,
               counter, shift_cnt, rest_cycle, rd_addr, finish_vec, busy, done
    );

    modport slave (
        input  start, num_iter, in_valid, x_in, y_in,
        output in_ready, x_value, y_value, enable, add_enable, res_enable,
               counter, shift_cnt, rest_cycle, rd_addr, finish_vec, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/online_div_ctrl_v3.sv
`default_nettype none
// ============================================================================
// Module      : online_div_ctrl_v3
// Description : Online divider sequencer: LOAD priming, then one COMP plus k
//               REST replay cycles per iteration k. Optional OLDIV_CTRL_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module online_div_ctrl_v3 #(
    parameter int UNROLL       = 64,
    parameter int ONLINE_DELAY = 2,
    parameter int ADDR_WIDTH   = 7,
    parameter int CNT_WIDTH    = 11,
    parameter int DIGIT_W      = 2
) (
    input  logic                 clk,
    input  logic                 asyn_reset_n,
    online_div_ctrl_v3_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_COMP = 3'd2,
        S_REST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  c_load_len  = CNT_WIDTH'(UNROLL + ONLINE_DELAY);
    localparam logic [CNT_WIDTH-1:0]  c_load_last = CNT_WIDTH'(UNROLL + ONLINE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0]  c_comp_last = CNT_WIDTH'(UNROLL - 1);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_accum_max = {ADDR_WIDTH{1'b1}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_counter,    w_counter_nxt;
    logic [ADDR_WIDTH-1:0] r_accum,      w_accum_nxt;
    logic [ADDR_WIDTH-1:0] r_rest_cycle, w_rest_cycle_nxt;
    logic [ADDR_WIDTH-1:0] r_iter_cnt,   w_iter_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_num_iter_q, w_num_iter_q_nxt;
    logic [DIGIT_W-1:0]    r_x_value,    w_x_value_nxt;
    logic [DIGIT_W-1:0]    r_y_value,    w_y_value_nxt;
    logic                  r_finish_vec, w_finish_vec_nxt;
    logic                  r_done,       w_done_nxt;
    logic                  r_aborted,    w_aborted_nxt;

    logic                  w_in_ready;
    logic                  w_enable;
    logic                  w_add_enable;
    logic                  w_res_enable;
    logic [CNT_WIDTH-1:0]  w_shift_cnt;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_accept;
    logic                  w_abort;

    assign w_accept = w_in_ready && bus.in_valid;

`ifdef OLDIV_CTRL_ABORT_EN
    assign w_abort = bus.abort &&
                     ((r_state == S_LOAD) || (r_state == S_COMP) || (r_state == S_REST));
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_counter_nxt    = r_counter;
        w_accum_nxt      = r_accum;
        w_rest_cycle_nxt = r_rest_cycle;
        w_iter_cnt_nxt   = r_iter_cnt;
        w_num_iter_q_nxt = r_num_iter_q;
        w_x_value_nxt    = r_x_value;
        w_y_value_nxt    = r_y_value;
        w_finish_vec_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_aborted_nxt    = 1'b0;
        w_in_ready       = 1'b0;
        w_enable         = 1'b0;
        w_add_enable     = 1'b0;
        w_res_enable     = 1'b0;
        w_shift_cnt      = '0;
        w_rd_addr        = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_num_iter_q_nxt = bus.num_iter;
                    w_counter_nxt    = '0;
                    w_iter_cnt_nxt   = '0;
                    w_state_nxt      = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready   = 1'b1;
                w_enable     = 1'b1;
                w_res_enable = 1'b1;
                w_shift_cnt  = c_load_len - r_counter;
                w_rd_addr    = r_finish_vec ? c_addr_one : '0;
                if (w_in_ready && bus.in_valid) begin
                    if (r_counter == c_load_last) begin
                        w_finish_vec_nxt = 1'b1;
                        w_counter_nxt    = '0;
                        w_accum_nxt      = c_addr_one;
                        w_state_nxt      = (r_num_iter_q == '0) ? S_DONE : S_COMP;
                    end else begin
                        w_counter_nxt = r_counter + c_cnt_one;
                    end
                end
            end
            S_COMP: begin
                w_in_ready   = 1'b1;
                w_enable     = 1'b1;
                w_add_enable = 1'b1;
                w_res_enable = 1'b1;
                w_shift_cnt  = c_comp_last - r_counter;
                if (w_in_ready && bus.in_valid) begin
                    w_iter_cnt_nxt   = r_iter_cnt + c_addr_one;
                    w_rest_cycle_nxt = r_accum;
                    w_state_nxt      = S_REST;
                    if (r_counter == c_comp_last) begin
                        w_counter_nxt    = '0;
                        w_finish_vec_nxt = 1'b1;
                    end else begin
                        w_counter_nxt = r_counter + c_cnt_one;
                    end
                end
            end
            S_REST: begin
                // Replays stored residuals newest-first; the adder fires on the oldest.
                w_res_enable     = 1'b1;
                w_shift_cnt      = c_comp_last - r_counter;
                w_rd_addr        = r_rest_cycle - c_addr_one;
                w_add_enable     = (r_rest_cycle == c_addr_one);
                w_rest_cycle_nxt = r_rest_cycle - c_addr_one;
                if (r_rest_cycle == c_addr_one) begin
                    if (r_iter_cnt == r_num_iter_q) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_accum_nxt = (r_accum == c_accum_max) ? r_accum : r_accum + c_addr_one;
                        w_state_nxt = S_COMP;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_accept && !w_abort) begin
            w_x_value_nxt = bus.x_in;
            w_y_value_nxt = bus.y_in;
        end

        if (w_abort) begin
            w_state_nxt      = S_IDLE;
            w_counter_nxt    = '0;
            w_accum_nxt      = '0;
            w_rest_cycle_nxt = '0;
            w_iter_cnt_nxt   = '0;
            w_finish_vec_nxt = 1'b0;
            w_aborted_nxt    = 1'b1;
        end

        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            r_counter    <= '0;
            r_accum      <= '0;
            r_rest_cycle <= '0;
            r_iter_cnt   <= '0;
            r_num_iter_q <= '0;
            r_x_value    <= '0;
            r_y_value    <= '0;
            r_finish_vec <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_counter    <= w_counter_nxt;
            r_accum      <= w_accum_nxt;
            r_rest_cycle <= w_rest_cycle_nxt;
            r_iter_cnt   <= w_iter_cnt_nxt;
            r_num_iter_q <= w_num_iter_q_nxt;
            r_x_value    <= w_x_value_nxt;
            r_y_value    <= w_y_value_nxt;
            r_finish_vec <= w_finish_vec_nxt;
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.enable     = w_enable;
    assign bus.add_enable = w_add_enable;
    assign bus.res_enable = w_res_enable;
    assign bus.shift_cnt  = w_shift_cnt;
    assign bus.rd_addr    = w_rd_addr;
    assign bus.counter    = r_counter;
    assign bus.rest_cycle = r_rest_cycle;
    assign bus.x_value    = r_x_value;
    assign bus.y_value    = r_y_value;
    assign bus.finish_vec = r_finish_vec;
    assign bus.done       = r_done;
    assign bus.busy       = (r_state != S_IDLE);

`ifdef OLDIV_CTRL_ABORT_EN
    assign bus.aborted = r_aborted;
`else
    logic w_unused_aborted;
    assign w_unused_aborted = r_aborted;
`endif

endmodule
`default_nettype wire

// File: tb/tb_online_div_ctrl_v3.sv
`default_nettype none
// ============================================================================
// Module      : tb_online_div_ctrl_v3
// Description : Scoreboard bench for online_div_ctrl_v3 (UNROLL=4, ONLINE_DELAY=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_online_div_ctrl_v3;
    localparam int U  = 4;
    localparam int OD = 2;
    localparam int LD = U + OD;
    localparam int AW = 7;
    localparam int CW = 11;
    localparam int DW = 2;

    typedef struct packed {
        logic          in_ready;
        logic          enable;
        logic          add_enable;
        logic          res_enable;
        logic          finish_vec;
        logic          done;
        logic [CW-1:0] counter;
        logic [CW-1:0] shift_cnt;
        logic [AW-1:0] rest_cycle;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] x_value;
        logic [DW-1:0] y_value;
    } rec_t;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } drv_t;

    logic clk = 1'b0;
    logic asyn_reset_n;
    always #5 clk = ~clk;

    online_div_ctrl_v3_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .DIGIT_W(DW)) bus ();

    online_div_ctrl_v3 #(
        .UNROLL(U), .ONLINE_DELAY(OD), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .DIGIT_W(DW)
    ) dut (
        .clk(clk),
        .asyn_reset_n(asyn_reset_n),
        .bus(bus)
    );

    int            errors = 0;
    int            checks = 0;
    int            rec_idx;
    int            busy_cnt;
    int            ready_cnt;
    int            dig = 1;
    bit            done_seen;
    logic [DW-1:0] exp_x, exp_y;
    rec_t          plan[$];
    rec_t          sb_q[$];
    drv_t          drv_q[$];

    function automatic rec_t act_rec();
        rec_t r;
        r.in_ready   = bus.in_ready;
        r.enable     = bus.enable;
        r.add_enable = bus.add_enable;
        r.res_enable = bus.res_enable;
        r.finish_vec = bus.finish_vec;
        r.done       = bus.done;
        r.counter    = bus.counter;
        r.shift_cnt  = bus.shift_cnt;
        r.rest_cycle = bus.rest_cycle;
        r.rd_addr    = bus.rd_addr;
        r.x_value    = bus.x_value;
        r.y_value    = bus.y_value;
        return r;
    endfunction

    // One expected busy cycle plus the stream digit driven during it.
    function automatic void step(input logic rdy, input logic en, input logic add,
                                 input logic res, input logic fv, input logic dn,
                                 input int cnt, input int shift, input int rest,
                                 input int rd, input logic v);
        rec_t          r;
        logic [DW-1:0] xd, yd;
        r.in_ready   = rdy;
        r.enable     = en;
        r.add_enable = add;
        r.res_enable = res;
        r.finish_vec = fv;
        r.done       = dn;
        r.counter    = CW'(cnt);
        r.shift_cnt  = CW'(shift);
        r.rest_cycle = AW'(rest);
        r.rd_addr    = AW'(rd);
        r.x_value    = exp_x;
        r.y_value    = exp_y;
        plan.push_back(r);
        xd = DW'(dig);
        yd = DW'(dig * 3 + 1);
        dig++;
        drv_q.push_back('{v: v, x: xd, y: yd});
        if (v && rdy) begin
            exp_x = xd;
            exp_y = yd;
        end
    endfunction

    function automatic void plan_run(input int n, input int ls_at, input int ls_len,
                                     input int cs_iter, input int cs_len);
        int   cnt;
        logic fv;
        plan.delete();
        drv_q.delete();
        fv = 1'b0;
        for (int i = 0; i < LD; i++) begin
            if (i == ls_at)
                for (int s = 0; s < ls_len; s++) step(1, 1, 0, 1, 0, 0, i, LD - i, 0, 0, 0);
            step(1, 1, 0, 1, 0, 0, i, LD - i, 0, 0, 1);
        end
        fv  = 1'b1;
        cnt = 0;
        for (int k = 1; k <= n; k++) begin
            if (k == cs_iter)
                for (int s = 0; s < cs_len; s++) begin
                    step(1, 1, 1, 1, fv, 0, cnt, U - 1 - cnt, 0, 0, 0);
                    fv = 1'b0;
                end
            step(1, 1, 1, 1, fv, 0, cnt, U - 1 - cnt, 0, 0, 1);
            if (cnt == U - 1) begin
                cnt = 0;
                fv  = 1'b1;
            end else begin
                cnt++;
                fv = 1'b0;
            end
            for (int r = k; r >= 1; r--) begin
                step(0, 0, (r == 1), 1, fv, 0, cnt, U - 1 - cnt, r, r - 1, 1);
                fv = 1'b0;
            end
        end
        step(0, 0, 0, 0, fv, 1, cnt, 0, 0, 0, 1);
        sb_q = plan;
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_seen = 1'b1;
        if (asyn_reset_n === 1'b1 && bus.busy === 1'b1) begin
            rec_t e, a;
            busy_cnt++;
            if (bus.in_ready === 1'b1) ready_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL extra_busy: busy=1 at cycle %0d, required busy=0", rec_idx);
            end else begin
                e = sb_q.pop_front();
                a = act_rec();
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_%0d: actual=%h required=%h (cnt %0d/%0d shift %0d/%0d rd %0d/%0d)",
                             rec_idx, a, e, a.counter, e.counter, a.shift_cnt, e.shift_cnt,
                             a.rd_addr, e.rd_addr);
                end
            end
            rec_idx++;
        end
    end

    // cut_kind: 0 none, 1 reset at cycle cut_at, 2 abort at cycle cut_at
    task automatic drive_run(input int n, input int restart_at, input int cut_at,
                             input int cut_kind, input int exp_len, input int exp_ready);
        bit cut;
        cut       = 1'b0;
        rec_idx   = 0;
        busy_cnt  = 0;
        ready_cnt = 0;
        done_seen = 1'b0;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.num_iter = AW'(n);
        for (int c = 0; c < drv_q.size(); c++) begin
            @(posedge clk); #1;
            bus.start    = (c == restart_at);
            bus.num_iter = AW'(n + 37);
            bus.in_valid = drv_q[c].v;
            bus.x_in     = drv_q[c].x;
            bus.y_in     = drv_q[c].y;
            if (c == cut_at) begin
                cut = 1'b1;
                if (cut_kind == 1) begin
                    asyn_reset_n = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (bus.busy !== 1'b0 || bus.counter !== '0 || bus.rd_addr !== '0 || bus.done !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_mid: busy=%b counter=%0d rd_addr=%0d done=%b, required 0/0/0/0",
                                 bus.busy, bus.counter, bus.rd_addr, bus.done);
                    end
                    @(posedge clk); #1;
                    asyn_reset_n = 1'b1;
                    bus.in_valid = 1'b0;
                    repeat (3) @(negedge clk);
                    checks++;
                    if (done_seen || bus.busy !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_no_done: done_seen=%0b busy=%b, required 0/0", done_seen, bus.busy);
                    end
                    exp_x = '0;
                    exp_y = '0;
                end
`ifdef OLDIV_CTRL_ABORT_EN
                else if (cut_kind == 2) begin
                    bus.abort = 1'b1;
                    @(posedge clk); #1;
                    bus.abort    = 1'b0;
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (bus.aborted !== 1'b1 || bus.busy !== 1'b0 || bus.counter !== '0 || bus.rest_cycle !== '0) begin
                        errors++;
                        $display("FAIL abort_pulse: aborted=%b busy=%b counter=%0d rest=%0d, required 1/0/0/0",
                                 bus.aborted, bus.busy, bus.counter, bus.rest_cycle);
                    end
                    @(negedge clk);
                    checks++;
                    if (bus.aborted !== 1'b0 || done_seen || bus.busy !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_after: aborted=%b done_seen=%0b busy=%b, required 0/0/0",
                                 bus.aborted, done_seen, bus.busy);
                    end
                    exp_x = plan[cut_at].x_value;
                    exp_y = plan[cut_at].y_value;
                end
`endif
                break;
            end
        end
        if (!cut) begin
            @(posedge clk); #1;
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || sb_q.size() != 0) begin
                errors++;
                $display("FAIL run_end: busy=%b done=%b left=%0d, required 0/0/0",
                         bus.busy, bus.done, sb_q.size());
            end
            checks++;
            if (busy_cnt != exp_len) begin
                errors++;
                $display("FAIL run_length: busy cycles=%0d required=%0d", busy_cnt, exp_len);
            end
            checks++;
            if (ready_cnt != exp_ready) begin
                errors++;
                $display("FAIL ready_count: in_ready cycles=%0d required=%0d", ready_cnt, exp_ready);
            end
        end
        for (int t = 0; t < 64 && bus.busy === 1'b1; t++) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b after 64 cycles, required 0", bus.busy);
        end
        sb_q.delete();
    endtask

    initial begin
        asyn_reset_n = 1'b0;
        bus.start    = 1'b0;
        bus.num_iter = '0;
        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        bus.y_in     = '0;
`ifdef OLDIV_CTRL_ABORT_EN
        bus.abort    = 1'b0;
`endif
        exp_x = '0;
        exp_y = '0;
        @(negedge clk);
        checks++;
        if (act_rec() !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h busy=%b, required 0/0", act_rec(), bus.busy);
        end
        @(posedge clk); #1;
        asyn_reset_n = 1'b1;

        plan_run(3, -1, 0, 0, 0);   drive_run(3, -1, -1, 0, 16, 9);
        plan_run(5, -1, 0, 0, 0);   drive_run(5, -1, -1, 0, 27, 11);
        plan_run(3, 2, 3, 2, 2);    drive_run(3, -1, -1, 0, 21, 14);
        plan_run(0, -1, 0, 0, 0);   drive_run(0, 6, -1, 0, 7, 6);
        plan_run(0, -1, 0, 0, 0);   drive_run(0, 3, -1, 0, 7, 6);
        plan_run(3, -1, 0, 0, 0);   drive_run(3, -1, 9, 1, 0, 0);
        plan_run(3, -1, 0, 0, 0);   drive_run(3, -1, -1, 0, 16, 9);
`ifdef OLDIV_CTRL_ABORT_EN
        plan_run(3, -1, 0, 0, 0);   drive_run(3, -1, 10, 2, 0, 0);
        plan_run(3, -1, 0, 0, 0);   drive_run(3, -1, -1, 0, 16, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required run completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/online_div_ctrl_v3.md
Name: online_div_ctrl_v3

Overview:
Parametrised successor to the online-divider computation controller. It sequences the digit streams into the online divider datapath:
- LOAD priming phase of UNROLL+ONLINE_DELAY digits.
- Triangular schedule of one COMP cycle followed by k REST (residual replay) cycles for iteration k.
- Adds a start/done handshake, an in_valid/in_ready stall on the digit stream, a programmable iteration count and a generic digit width.

Parameters:
- UNROLL, 64, digits per vector; counter wrap point in COMP.
- ONLINE_DELAY, 2, online delay digits added to the LOAD phase.
- ADDR_WIDTH, 7, width of accum, rest_cycle, rd_addr and num_iter.
- CNT_WIDTH, 11, width of counter and shift_cnt.
- DIGIT_W, 2, width of one signed-digit (x/y) input.

Ports:
- clk  in  1  single clock, rising edge.
- asyn_reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run when in IDLE.
- num_iter  in  ADDR_WIDTH  number of COMP iterations; sampled with start.
- in_valid  in  1  x_in/y_in hold a valid digit.
- x_in  in  DIGIT_W  dividend digit.
- y_in  in  DIGIT_W  divisor digit.
- in_ready  out  1  digit accepted this cycle when in_valid is also high.
- x_value  out  DIGIT_W  registered captured x digit.
- y_value  out  DIGIT_W  registered captured y digit.
- enable  out  1  datapath step enable.
- add_enable  out  1  residual adder enable.
- res_enable  out  1  residual memory enable.
- counter  out  CNT_WIDTH  digit counter.
- shift_cnt  out  CNT_WIDTH  alignment shift amount.
- rest_cycle  out  ADDR_WIDTH  REST cycles remaining.
- rd_addr  out  ADDR_WIDTH  residual memory read address.
- finish_vec  out  1  vector-boundary pulse.
- busy  out  1  run in progress.
- done  out  1  one-cycle end-of-run pulse.

Behaviour:
- Reset (asyn_reset_n low, any state): state=IDLE; counter, accum, rest_cycle, iter_cnt, x_value, y_value, finish_vec, done all 0. Reset mid-run aborts immediately with no done pulse.
- Registered state: state, counter, accum, rest_cycle, iter_cnt, num_iter_q, x_value, y_value, finish_vec, done. All other outputs are combinational decode of these registers.
- An accept is in_ready && in_valid. On every accept, x_value/y_value capture x_in/y_in.
- IDLE: in_ready=0, enable=0, add_enable=0, res_enable=0, rd_addr=0, shift_cnt=0, busy=0.
  - start=1: num_iter_q<=num_iter, counter<=0, iter_cnt<=0, go to LOAD.
  - start is ignored in all other states.
- LOAD: in_ready=1, enable=1, res_enable=1, shift_cnt=UNROLL+ONLINE_DELAY-counter, rd_addr=finish_vec?1:0.
  - Each accept: counter++.
  - Accept with counter==UNROLL+ONLINE_DELAY-1: finish_vec<=1, counter<=0, accum<=1.
    - If num_iter_q==0, go to DONE.
    - Otherwise go to COMP.
  - No accept: all registers hold (stall).
- COMP: in_ready=1, enable=1, add_enable=1, res_enable=1, shift_cnt=UNROLL-1-counter, rd_addr=0.
  - On accept: iter_cnt++, rest_cycle<=accum, go to REST.
    - If counter==UNROLL-1: counter<=0, finish_vec<=1.
    - Otherwise: counter++, finish_vec<=0.
  - No accept: stall in COMP.
- REST (no stream consumption): in_ready=0, enable=0, res_enable=1, shift_cnt=UNROLL-1-counter, rd_addr=rest_cycle-1, add_enable=(rest_cycle==1). rest_cycle decrements each cycle.
  - On rest_cycle==1:
    - If iter_cnt==num_iter_q, go to DONE.
    - Otherwise accum<=accum+1, saturating at 2^ADDR_WIDTH-1, and go to COMP.
- DONE: one cycle; done=1, outputs as IDLE except busy=1. Then go to IDLE.
- busy=1 in LOAD, COMP, REST and DONE.
- finish_vec is a one-cycle pulse: cleared on any cycle it is not set.
- Arithmetic: all arithmetic is unsigned modulo register width. shift_cnt is computed at CNT_WIDTH.

Optional Feature:
- Macro: OLDIV_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in LOAD, COMP or REST forces IDLE on the next edge; counter, accum, rest_cycle and iter_cnt clear; no done pulse; also adds output aborted, a one-cycle pulse on that edge. abort has priority over accept and over the REST exit.
- Undefined: no abort/aborted ports; behaviour exactly as above.

Test Plan:
- Reset while in REST (UNROLL=4, ONLINE_DELAY=2) -> next cycle state IDLE, busy=0, counter=0, rd_addr=0, done never asserted.
- UNROLL=4, ONLINE_DELAY=2, num_iter=3, in_valid=1 constantly, start pulse -> exact sequence LOAD×6, COMP, REST×1, COMP, REST×2, COMP, REST×3, DONE (16 cycles); in_ready high in 9 cycles; done on cycle 17 after start. Expected outputs in that run:
  - LOAD shift_cnt 6,5,4,3,2,1.
  - finish_vec high in first COMP cycle.
  - Last REST group rd_addr 2,1,0 with add_enable high only on rd_addr=0.
- Same config, num_iter=5 -> 4th COMP sees counter=3, wraps counter to 0 and pulses finish_vec; 5th COMP shows counter=0, shift_cnt=3.
- Stall: in_valid low for 3 cycles at LOAD counter=2, and again for 2 cycles in COMP -> state, counter, x_value and y_value frozen during the stall; total run lengthens by exactly 5 cycles.
- num_iter=0 -> LOAD×6 then DONE; no COMP or REST cycles. A start asserted mid-run is ignored and num_iter changes mid-run have no effect.
- With OLDIV_CTRL_ABORT_EN: abort in 2nd REST of iteration 2 -> aborted pulse, IDLE next cycle, no done. A following start runs a clean full sequence.
